// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: output register with set/clear/toggle aliases, synchronised inputs,
// sticky rising-edge capture (write-1-to-clear) and a maskable registered interrupt.
module mmio_gpio #(
   parameter int                WIDTH       = 4,
   parameter logic [31:0]       BASE_ADDR   = 32'h0000_0054,
   parameter logic [WIDTH-1:0]  RESET_OUT   = '0,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              memwrite,
   input  logic [31:0]       addr,
   input  logic [31:0]       wd,
   output logic [31:0]       rd,
   output logic              hit,
   input  logic [WIDTH-1:0]  gpio_in,
   output logic [WIDTH-1:0]  gpio_out,
   output logic              irq
);

   localparam logic [31:0] A_OUT  = BASE_ADDR;
   localparam logic [31:0] A_SET  = BASE_ADDR + 32'h04;
   localparam logic [31:0] A_CLR  = BASE_ADDR + 32'h08;
   localparam logic [31:0] A_TGL  = BASE_ADDR + 32'h0C;
   localparam logic [31:0] A_IN   = BASE_ADDR + 32'h10;
   localparam logic [31:0] A_EDGE = BASE_ADDR + 32'h14;
   localparam logic [31:0] A_IEN  = BASE_ADDR + 32'h18;

   logic sel_out, sel_set, sel_clr, sel_tgl, sel_in, sel_edge, sel_ien;
   logic [WIDTH-1:0] wdw;

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] sync, prev_q, rise;
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] edge_q, edge_d, w1c_mask;
   logic [WIDTH-1:0] ien_q, ien_d;
   logic             irq_q;
   logic [WIDTH-1:0] rd_w;

   assign sel_out  = (addr == A_OUT);
   assign sel_set  = (addr == A_SET);
   assign sel_clr  = (addr == A_CLR);
   assign sel_tgl  = (addr == A_TGL);
   assign sel_in   = (addr == A_IN);
   assign sel_edge = (addr == A_EDGE);
   assign sel_ien  = (addr == A_IEN);

   assign hit = sel_out | sel_set | sel_clr | sel_tgl | sel_in | sel_edge | sel_ien;
   assign wdw = wd[WIDTH-1:0];

   // Input synchroniser; prev is one stage beyond the chain so rise is a single-cycle pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         sync_q[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++)
            sync_q[i] <= sync_q[i-1];
         prev_q <= sync;
      end
   end

   assign sync = sync_q[SYNC_STAGES-1];
   assign rise = sync & ~prev_q;

   always_comb begin
      out_d = out_q;
      ien_d = ien_q;
      if (memwrite) begin
         if (sel_out) out_d = wdw;
         if (sel_set) out_d = out_q | wdw;
         if (sel_clr) out_d = out_q & ~wdw;
         if (sel_tgl) out_d = out_q ^ wdw;
         if (sel_ien) ien_d = wdw;
      end
   end

   // OR-ing rise after the clear makes a coincident capture win over the W1C.
   assign w1c_mask = (memwrite && sel_edge) ? wdw : '0;
   assign edge_d   = (edge_q & ~w1c_mask) | rise;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q  <= RESET_OUT;
         edge_q <= '0;
         ien_q  <= '0;
         irq_q  <= 1'b0;
      end else begin
         out_q  <= out_d;
         edge_q <= edge_d;
         ien_q  <= ien_d;
         irq_q  <= |(edge_q & ien_q);
      end
   end

   assign gpio_out = out_q;
   assign irq      = irq_q;

   always_comb begin
      rd_w = '0;
      if (sel_out | sel_set | sel_clr | sel_tgl) rd_w = out_q;
      if (sel_in)   rd_w = sync;
      if (sel_edge) rd_w = edge_q;
      if (sel_ien)  rd_w = ien_q;
   end

   always_comb begin
      rd = '0;
      rd[WIDTH-1:0] = rd_w;
   end

endmodule

// File: tb/tb_mmio_gpio.sv
// Bench for mmio_gpio: directed vector table, hand-written edge/reset sequences and a
// randomized run against a delay-line reference model.
module tb_mmio_gpio;

   localparam int          W    = 4;
   localparam int          SS   = 2;
   localparam logic [31:0] BASE = 32'h0000_0054;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] addr, wd, rd;
   logic        hit, irq;
   logic [W-1:0] gpio_in, gpio_out;

   int n_tests = 0;
   int n_fail  = 0;

   mmio_gpio #(.WIDTH(W), .BASE_ADDR(BASE), .RESET_OUT(4'h0), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr), .wd(wd), .rd(rd),
      .hit(hit), .gpio_in(gpio_in), .gpio_out(gpio_out), .irq(irq));

   always #5 clk = ~clk;

   // Reference model: inputs seen as a delay line of samples; hist[0] is the newest.
   logic [W-1:0] m_out, m_edge, m_en;
   logic         m_irq;
   logic [W-1:0] hist [0:SS];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_out <= '0; m_edge <= '0; m_en <= '0; m_irq <= 1'b0;
         for (int i = 0; i <= SS; i++) hist[i] <= '0;
      end else begin
         if (memwrite && addr == BASE)        m_out <= wd[W-1:0];
         if (memwrite && addr == BASE + 4)    m_out <= m_out | wd[W-1:0];
         if (memwrite && addr == BASE + 8)    m_out <= m_out & ~wd[W-1:0];
         if (memwrite && addr == BASE + 12)   m_out <= m_out ^ wd[W-1:0];
         if (memwrite && addr == BASE + 24)   m_en  <= wd[W-1:0];
         m_edge <= (m_edge & ~((memwrite && addr == BASE + 20) ? wd[W-1:0] : 4'h0))
                   | (hist[SS-1] & ~hist[SS]);
         m_irq <= |(m_edge & m_en);
         hist[0] <= gpio_in;
         for (int i = 1; i <= SS; i++) hist[i] <= hist[i-1];
      end
   end

   function automatic logic [31:0] exp_rd(input logic [31:0] a);
      if (a == BASE || a == BASE + 4 || a == BASE + 8 || a == BASE + 12) return {28'h0, m_out};
      if (a == BASE + 16) return {28'h0, hist[SS-1]};
      if (a == BASE + 20) return {28'h0, m_edge};
      if (a == BASE + 24) return {28'h0, m_en};
      return 32'h0;
   endfunction

   function automatic logic exp_hit(input logic [31:0] a);
      return (a >= BASE) && (a <= BASE + 24) && (a[1:0] == 2'b00);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One bus cycle: present inputs, pass one rising edge, then drop memwrite.
   task automatic cyc(input logic mw, input logic [31:0] a, input logic [31:0] w);
      memwrite = mw; addr = a; wd = w;
      @(negedge clk);
      memwrite = 1'b0;
   endtask

   task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(name, rd, exp);
   endtask

   typedef struct {
      logic        mw;
      logic [31:0] a;
      logic [31:0] w;
      logic [31:0] ra;
      logic [3:0]  e_out;
      logic [31:0] e_rd;
      logic        e_hit;
   } vec_t;

   vec_t vt [10];

   initial begin
      vt[0] = '{1'b1, 32'h54, 32'h0000_0005, 32'h54, 4'h5, 32'h5, 1'b1};
      vt[1] = '{1'b1, 32'h58, 32'hFFFF_FFFA, 32'h58, 4'hF, 32'hF, 1'b1};
      vt[2] = '{1'b1, 32'h5C, 32'hFFFF_FFF3, 32'h54, 4'hC, 32'hC, 1'b1};
      vt[3] = '{1'b1, 32'h60, 32'hFFFF_FFFF, 32'h60, 4'h3, 32'h3, 1'b1};
      vt[4] = '{1'b1, 32'h50, 32'h0000_000F, 32'h50, 4'h3, 32'h0, 1'b0};
      vt[5] = '{1'b1, 32'h70, 32'hFFFF_FFFF, 32'h70, 4'h3, 32'h0, 1'b0};
      vt[6] = '{1'b1, 32'h55, 32'h0000_0000, 32'h55, 4'h3, 32'h0, 1'b0};
      vt[7] = '{1'b1, 32'h64, 32'h0000_000F, 32'h64, 4'h3, 32'h0, 1'b1};
      vt[8] = '{1'b1, 32'h6C, 32'hFFFF_FFF5, 32'h6C, 4'h3, 32'h5, 1'b1};
      vt[9] = '{1'b1, 32'h6C, 32'h0000_0000, 32'h6C, 4'h3, 32'h0, 1'b1};

      reset = 1'b0; memwrite = 1'b0; addr = 32'h54; wd = '0; gpio_in = '0;
      repeat (3) @(negedge clk);
      chk("rst_out", {28'h0, gpio_out}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      rdchk("rst_rd", 32'h54, 32'h0);
      chk("rst_hit", {31'h0, hit}, 32'h1);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         cyc(vt[i].mw, vt[i].a, vt[i].w);
         addr = vt[i].ra;
         #1;
         chk($sformatf("vec%0d_out", i), {28'h0, gpio_out}, {28'h0, vt[i].e_out});
         chk($sformatf("vec%0d_rd", i), rd, vt[i].e_rd);
         chk($sformatf("vec%0d_hit", i), {31'h0, hit}, {31'h0, vt[i].e_hit});
      end

      // Edge capture latency, irq, and W1C
      cyc(1'b1, 32'h6C, 32'h4);
      gpio_in = 4'h4;
      cyc(1'b0, 32'h64, 32'h0);
      rdchk("in_e0", 32'h64, 32'h0);
      cyc(1'b0, 32'h64, 32'h0);
      rdchk("in_e1", 32'h64, 32'h4);
      rdchk("edge_e1", 32'h68, 32'h0);
      cyc(1'b0, 32'h68, 32'h0);
      rdchk("edge_e2", 32'h68, 32'h4);
      chk("irq_e2", {31'h0, irq}, 32'h0);
      cyc(1'b0, 32'h68, 32'h0);
      chk("irq_e3", {31'h0, irq}, 32'h1);
      cyc(1'b1, 32'h68, 32'h4);
      rdchk("edge_w1c", 32'h68, 32'h0);
      chk("irq_w1c_hold", {31'h0, irq}, 32'h1);
      cyc(1'b0, 32'h68, 32'h0);
      chk("irq_w1c_drop", {31'h0, irq}, 32'h0);

      // Clear coinciding with a fresh rise on the same bit
      cyc(1'b1, 32'h6C, 32'h6);
      gpio_in = 4'h6;
      repeat (4) cyc(1'b0, 32'h68, 32'h0);
      rdchk("sim_pre_edge", 32'h68, 32'h2);
      chk("sim_pre_irq", {31'h0, irq}, 32'h1);
      gpio_in = 4'h4;
      repeat (4) cyc(1'b0, 32'h68, 32'h0);
      gpio_in = 4'h6;
      cyc(1'b0, 32'h68, 32'h0);
      cyc(1'b0, 32'h68, 32'h0);
      cyc(1'b1, 32'h68, 32'h2);
      rdchk("sim_edge_kept", 32'h68, 32'h2);
      chk("sim_irq_kept", {31'h0, irq}, 32'h1);
      cyc(1'b0, 32'h68, 32'h0);
      chk("sim_irq_after", {31'h0, irq}, 32'h1);
      cyc(1'b1, 32'h68, 32'h2);
      rdchk("sim_clr_ok", 32'h68, 32'h0);
      cyc(1'b0, 32'h68, 32'h0);
      chk("sim_irq_drop", {31'h0, irq}, 32'h0);

      // Asynchronous reset between clock edges
      cyc(1'b1, 32'h54, 32'hF);
      gpio_in = 4'h0;
      repeat (4) cyc(1'b0, 32'h68, 32'h0);
      cyc(1'b1, 32'h68, 32'hF);
      cyc(1'b1, 32'h6C, 32'hF);
      gpio_in = 4'h3;
      repeat (5) cyc(1'b0, 32'h68, 32'h0);
      rdchk("pre_rst_edge", 32'h68, 32'h3);
      chk("pre_rst_irq", {31'h0, irq}, 32'h1);
      chk("pre_rst_out", {28'h0, gpio_out}, 32'hF);
      #1;
      reset = 1'b0; gpio_in = 4'h0;
      #1;
      chk("arst_out", {28'h0, gpio_out}, 32'h0);
      chk("arst_irq", {31'h0, irq}, 32'h0);
      rdchk("arst_edge", 32'h68, 32'h0);
      rdchk("arst_ien", 32'h6C, 32'h0);
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      repeat (4) cyc(1'b0, 32'h68, 32'h0);
      rdchk("post_rst_edge", 32'h68, 32'h0);
      chk("post_rst_irq", {31'h0, irq}, 32'h0);
      chk("post_rst_out", {28'h0, gpio_out}, 32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         int r;
         r = $urandom_range(0, 9);
         memwrite = $urandom_range(0, 1);
         if (r < 7)       addr = BASE + 32'(4 * r);
         else if (r == 7) addr = 32'h50;
         else if (r == 8) addr = 32'h70;
         else             addr = BASE + 32'($urandom_range(0, 27));
         wd = $urandom;
         if ($urandom_range(0, 3) == 0) gpio_in = 4'($urandom);
         #1;
         chk("rnd_rd", rd, exp_rd(addr));
         chk("rnd_hit", {31'h0, hit}, {31'h0, exp_hit(addr)});
         @(negedge clk);
         chk("rnd_out", {28'h0, gpio_out}, {28'h0, m_out});
         chk("rnd_irq", {31'h0, irq}, {31'h0, m_irq});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
